// File: rtl/ca_pkg.sv
// ca_pkg -- shared constants and FSM state type for the elementary cellular
// automaton row generator.
//
// Contents:
//   CA_CELLS    cells per automaton row
//   CA_BYTES    bytes per row as written to the debug RAM
//   CA_MAX_ROWS largest supported number of rows per run
//   ROW_W       width of the row field of the debug RAM address
//   BYTE_W      width of the byte field of the debug RAM address
//   ADDR_W      full debug RAM address width {row, byte}
//   ca_state_e  generator FSM states
package ca_pkg;

    localparam int CA_CELLS    = 128;
    localparam int CA_BYTES    = 16;
    localparam int CA_MAX_ROWS = 64;
    localparam int ROW_W       = 6;
    localparam int BYTE_W      = 4;
    localparam int ADDR_W      = ROW_W + BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } ca_state_e;

endpackage

// File: rtl/ca_rule_step.sv
// ca_rule_step -- combinational next-generation function of an elementary
// cellular automaton over one 128-cell row.
//
// Bit i of a row vector is cell i. Each next cell is the rule bit selected by
// the 3-bit neighbourhood {cell(i-1), cell(i), cell(i+1)}.
//
// Build option:
//   CA_WRAP_EN  defined   -> toroidal boundary, cell(-1)=cell 127, cell(128)=cell 0
//               undefined -> neighbours outside the row read as 0
//
// Ports:
//   i_row      current row, bit i = cell i
//   i_rule     elementary CA rule number
//   o_next_row next row
module ca_rule_step
    import ca_pkg::*;
(
    input  logic [CA_CELLS-1:0] i_row,
    input  logic [7:0]          i_rule,
    output logic [CA_CELLS-1:0] o_next_row
);

    // Row padded with one boundary cell each side: w_ext[j+1] holds cell j,
    // so w_ext[0] is cell(-1) and w_ext[CA_CELLS+1] is cell(CA_CELLS).
    logic [CA_CELLS+1:0] w_ext;

`ifdef CA_WRAP_EN
    assign w_ext = {i_row[0], i_row, i_row[CA_CELLS-1]};
`else
    assign w_ext = {1'b0, i_row, 1'b0};
`endif

    for (genvar i = 0; i < CA_CELLS; i++) begin : g_cell
        assign o_next_row[i] = i_rule[{w_ext[i], w_ext[i+1], w_ext[i+2]}];
    end

endmodule

// File: rtl/ca_row_generator.sv
// ca_row_generator -- runs an elementary cellular automaton for ROWS
// generations from a single live seed cell and streams every row, 16 bytes
// per row, into a debug RAM write port.
//
// Cell i of a row lands in byte i/8, bit 7-(i mod 8) (bit 7 leftmost).
// Each row is written over 16 consecutive cycles, followed by one cycle that
// computes the next generation; a run is ROWS*17-1 cycles from the first
// write to the done pulse.
//
// Build option: CA_WRAP_EN selects a toroidal boundary (see ca_rule_step);
// the default build uses zero boundary cells.
//
// Parameters:
//   ROWS      rows generated per run, 2..64
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, has priority over start
//   start     one-cycle request to begin a run (ignored while busy)
//   rule      CA rule number, sampled with start
//   seed_pos  index of the single live cell in row 0, sampled with start
//   wr_en     debug RAM write strobe
//   wr_addr   debug RAM address {row[5:0], byte[3:0]}, held while wr_en low
//   wr_data   debug RAM byte, held while wr_en low
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse after the last write of a run
module ca_row_generator
    import ca_pkg::*;
#(
    parameter int ROWS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rule,
    input  logic [6:0]        seed_pos,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);

    ca_state_e             r_state;
    ca_state_e             w_next_state;
    logic [CA_CELLS-1:0]   r_row;
    logic [CA_CELLS-1:0]   w_next_row;
    logic [ROW_W-1:0]      r_row_cnt;
    logic [BYTE_W-1:0]     r_byte_cnt;
    logic [7:0]            r_rule;
    logic [7:0]            w_byte;
    logic                  w_last_byte;
    logic                  w_last_row;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_busy;
    logic                  r_done;

    assign w_last_byte = (r_byte_cnt == BYTE_W'(CA_BYTES - 1));
    assign w_last_row  = (r_row_cnt == ROW_W'(ROWS - 1));

    ca_rule_step u_rule_step (
        .i_row      (r_row),
        .i_rule     (r_rule),
        .o_next_row (w_next_row)
    );

    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a path that left w_next_state unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = WRITE;
            WRITE:   if (w_last_byte) w_next_state = w_last_row ? DONE : STEP;
            STEP:    w_next_state = WRITE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Row register, counters and the latched rule. The row is a plain
    // register (not a RAM), so it is cleared by reset along with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '0;
            r_row_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rule     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rule     <= rule;
                        r_row      <= CA_CELLS'(1) << seed_pos;
                        r_row_cnt  <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                WRITE: begin
                    r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                end
                STEP: begin
                    r_row      <= w_next_row;
                    r_row_cnt  <= r_row_cnt + ROW_W'(1);
                    r_byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Byte r_byte_cnt of the current row: cell 8*byte+k goes to bit 7-k.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < 8; k++) begin
            w_byte[7-k] = r_row[{r_byte_cnt, 3'(k)}];
        end
    end

    // Output registers trail the FSM by one cycle; write strobe, done and
    // busy share that delay so the run timing is preserved at the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= (r_state == WRITE);
            r_done  <= (r_state == DONE);
            if (r_state == WRITE) begin
                r_wr_addr <= {r_row_cnt, r_byte_cnt};
                r_wr_data <= w_byte;
            end
            if (r_state == IDLE && start) begin
                r_busy <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_ca_row_generator.sv
// tb_ca_row_generator -- self-checking bench for ca_row_generator.
// Captured writes are compared against a cell-array reference model of the
// elementary CA; the boundary mode follows CA_WRAP_EN.
module tb_ca_row_generator;

    localparam int ROWS    = 64;
    localparam int N_CELLS = 128;
    localparam int N_BYTES = 16;
    localparam int RUN_LEN = ROWS * 17 - 1;
`ifdef CA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rule;
    logic [6:0] seed_pos;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    int           cyc = 0;
    logic [17:0]  cap_q[$];
    logic [17:0]  exp_q[$];
    int           first_wr = -1;
    int           done_cnt = 0;
    int           done_at  = -1;

    ca_row_generator #(.ROWS(ROWS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rule     (rule),
        .seed_pos (seed_pos),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            cap_q.push_back({wr_addr, wr_data});
            if (first_wr < 0) first_wr = cyc;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_at  = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: evolve a cell array generation by generation and list
    // every expected {addr, data} write in order.
    task automatic build_model(input int ru, input int seed);
        bit cur[N_CELLS];
        bit nxt[N_CELLS];
        exp_q.delete();
        for (int i = 0; i < N_CELLS; i++) cur[i] = (i == seed);
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < N_BYTES; b++) begin
                int val = 0;
                int addr = r * N_BYTES + b;
                for (int k = 0; k < 8; k++) val = val * 2 + int'(cur[8*b+k]);
                exp_q.push_back({addr[9:0], val[7:0]});
            end
            for (int i = 0; i < N_CELLS; i++) begin
                int l = (i == 0) ? (WRAP ? int'(cur[N_CELLS-1]) : 0) : int'(cur[i-1]);
                int c = int'(cur[i]);
                int rr = (i == N_CELLS-1) ? (WRAP ? int'(cur[0]) : 0) : int'(cur[i+1]);
                int idx = 4*l + 2*c + rr;
                nxt[i] = bit'((ru >> idx) & 1);
            end
            cur = nxt;
        end
    endtask

    function automatic logic [7:0] cap_byte(input int r, input int b);
        int idx = r * N_BYTES + b;
        if (idx < cap_q.size()) return cap_q[idx][7:0];
        return 8'hxx;
    endfunction

    // Pulse start with the given rule/seed, then scramble the inputs so a run
    // that re-sampled them would diverge from the model.
    task automatic start_run(input logic [7:0] r, input logic [6:0] s);
        cap_q.delete();
        first_wr = -1;
        done_cnt = 0;
        done_at  = -1;
        rule = r;
        seed_pos = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rule = 8'($urandom);
        seed_pos = 7'($urandom);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < RUN_LEN + 200) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (done_cnt == 0) begin
            n_errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
        end
        tick(4);
    endtask

    task automatic check_run(input int ru, input int seed, input string name);
        int bad = 0;
        int first_bad = -1;
        build_model(ru, seed);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s_count: got %0d writes want %0d", name, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s_data: %0d bad writes, first #%0d got addr=%h data=%h want addr=%h data=%h",
                     name, bad, first_bad, cap_q[first_bad][17:8], cap_q[first_bad][7:0],
                     exp_q[first_bad][17:8], exp_q[first_bad][7:0]);
        end
        n_checks++;
        if (done_at - first_wr != RUN_LEN) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles want %0d", name, done_at - first_wr, RUN_LEN);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt);
        end
        n_checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_idle: got busy=%b wr_en=%b want 0 0", name, busy, wr_en);
        end
        n_checks++;
        if ({wr_addr, wr_data} !== exp_q[exp_q.size()-1]) begin
            n_errors++;
            $display("FAIL %s_hold: got addr=%h data=%h want %h", name, wr_addr, wr_data,
                     exp_q[exp_q.size()-1]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        rule = 8'd90;
        seed_pos = 7'd64;
        tick(3);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, done} !== 21'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h busy=%b done=%b want all 0",
                     wr_en, wr_addr, wr_data, busy, done);
        end
        // start asserted throughout reset must not have launched a run
        start = 1'b0;
        rst = 1'b0;
        cap_q.delete();
        tick(20);
        n_checks++;
        if (cap_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_priority: got %0d writes busy=%b want 0 0", cap_q.size(), busy);
        end
    endtask

    task automatic test_rule204;
        start_run(8'd204, 7'd64);
        wait_done("rule204");
        check_run(204, 64, "rule204");
        n_checks++;
        if (cap_byte(37, 8) !== 8'h80 || cap_byte(37, 7) !== 8'h00) begin
            n_errors++;
            $display("FAIL rule204_row37: got b8=%h b7=%h want 80 00", cap_byte(37, 8), cap_byte(37, 7));
        end
    endtask

    task automatic test_rule90;
        start_run(8'd90, 7'd64);
        wait_done("rule90");
        check_run(90, 64, "rule90");
        n_checks++;
        if (cap_byte(1, 7) !== 8'h01 || cap_byte(1, 8) !== 8'h40) begin
            n_errors++;
            $display("FAIL rule90_row1: got b7=%h b8=%h want 01 40", cap_byte(1, 7), cap_byte(1, 8));
        end
        n_checks++;
        if (cap_byte(2, 7) !== 8'h02 || cap_byte(2, 8) !== 8'h20) begin
            n_errors++;
            $display("FAIL rule90_row2: got b7=%h b8=%h want 02 20", cap_byte(2, 7), cap_byte(2, 8));
        end
    endtask

    task automatic test_rule170_boundary;
        logic [7:0] want;
        want = WRAP ? 8'h01 : 8'h00;
        start_run(8'd170, 7'd0);
        wait_done("rule170");
        check_run(170, 0, "rule170");
        n_checks++;
        if (cap_byte(1, 15) !== want || cap_byte(1, 0) !== 8'h00) begin
            n_errors++;
            $display("FAIL rule170_row1: got b15=%h b0=%h want %h 00", cap_byte(1, 15), cap_byte(1, 0), want);
        end
    endtask

    task automatic test_rule0;
        int nz = 0;
        start_run(8'd0, 7'd127);
        wait_done("rule0");
        check_run(0, 127, "rule0");
        for (int r = 1; r < ROWS; r++)
            for (int b = 0; b < N_BYTES; b++)
                if (cap_byte(r, b) !== 8'h00) nz++;
        n_checks++;
        if (nz != 0 || cap_byte(0, 15) !== 8'h01) begin
            n_errors++;
            $display("FAIL rule0_rows: got %0d nonzero bytes, row0 b15=%h want 0, 01", nz, cap_byte(0, 15));
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 3; t++) begin
            logic [7:0] r = 8'($urandom);
            logic [6:0] s = 7'($urandom_range(0, 127));
            start_run(r, s);
            wait_done("random");
            check_run(int'(r), int'(s), "random");
        end
    endtask

    task automatic test_start_during_run;
        start_run(8'd30, 7'd64);
        tick(499);
        start = 1'b1;
        rule = 8'd204;
        seed_pos = 7'd3;
        tick(1);
        start = 1'b0;
        wait_done("restart");
        check_run(30, 64, "restart");
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] r;
        logic [6:0] s;
        start_run(8'd110, 7'd100);
        tick(299);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_outputs: got wr_en=%b busy=%b done=%b want 0 0 0", wr_en, busy, done);
        end
        cap_q.delete();
        done_cnt = 0;
        tick(1);
        rst = 1'b0;
        tick(RUN_LEN);
        n_checks++;
        if (cap_q.size() != 0 || done_cnt != 0) begin
            n_errors++;
            $display("FAIL abort_quiet: got %0d writes %0d done want 0 0", cap_q.size(), done_cnt);
        end
        r = 8'($urandom);
        s = 7'($urandom_range(0, 127));
        start_run(r, s);
        wait_done("after_abort");
        check_run(int'(r), int'(s), "after_abort");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rule = '0;
        seed_pos = '0;
        test_reset;
        test_rule204;
        test_rule90;
        test_rule170_boundary;
        test_rule0;
        test_random;
        test_start_during_run;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
